// File: rtl/diff_avg_pkg.sv
// Shared widths and types for the diff_avg boxcar averager.
package diff_avg_pkg;

    localparam int unsigned DATA_W = 20;
    localparam int unsigned DROP_W = 8;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Sum of 2^log2_n DATA_W-bit samples needs log2_n extra bits of headroom.
    function automatic int unsigned acc_width(input int unsigned log2_n);
        return DATA_W + log2_n;
    endfunction

endpackage

// File: rtl/diff_avg_if.sv
// Valid/ready stream carrying averages from diff_avg to the readout logic.
interface diff_avg_if;
    import diff_avg_pkg::*;

    sample_t o_data;
    logic    o_valid;
    logic    i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; head is valid whenever empty is low.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]  wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[ADDR_W-1:0]];

    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the head slot that the push overwrites.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
        end else if (do_push && !clr) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/diff_avg.sv
// Boxcar average of 2^LOG2_N pair-sum results, decimated and buffered in a FWFT FIFO,
// with sticky overflow flag and saturating drop counter.
module diff_avg
    import diff_avg_pkg::*;
#(
    parameter int unsigned LOG2_N     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  sample_t           i_data,
    input  logic              i_dval,
    input  logic              clr,
    diff_avg_if.master        out,
    output logic              o_ovf,
    output logic [DROP_W-1:0] o_drop_cnt
);

    localparam int unsigned ACC_W = acc_width(LOG2_N);

    logic                    dval_q;
    logic                    strobe;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] data_ext, sum, sum_shr;
    logic [LOG2_N-1:0]       cnt_q, cnt_d;
    sample_t                 avg;
    logic                    push, pop, drop;
    logic                    fifo_full, fifo_empty;
    sample_t                 fifo_head;
    logic                    ovf_q, ovf_d;
    logic [DROP_W-1:0]       drop_q, drop_d;

    // dval_q resets high so a strobe held high out of reset is not a sample.
    assign strobe   = i_dval & ~dval_q;
    assign data_ext = {{LOG2_N{i_data[DATA_W-1]}}, i_data};
    assign sum      = acc_q + data_ext;
    assign sum_shr  = sum >>> LOG2_N;
    assign avg      = sum_shr[DATA_W-1:0];

    assign pop  = out.o_valid & out.i_ready;
    assign drop = push & fifo_full & ~pop;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (strobe) begin
            if (cnt_q == '1) begin
                acc_d = '0;
                cnt_d = '0;
                push  = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + LOG2_N'(1);
            end
        end
    end

    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dval_q <= 1'b1;
            acc_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            dval_q <= i_dval;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .push_data (avg),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign out.o_data  = fifo_head;
    assign out.o_valid = ~fifo_empty;
    assign o_ovf       = ovf_q;
    assign o_drop_cnt  = drop_q;

endmodule
